// File: rtl/noc_router_pkg.sv
// Shared types and constants for the mesh router input path.
package noc_router_pkg;

  localparam int unsigned FLIT_TYPE_W = 2;

  // TTL field location inside a head flit
  localparam int unsigned TTL_LSB = 8;
  localparam int unsigned TTL_MSB = 19;

  typedef enum logic [1:0] {
    BODY     = 2'b00,
    HEAD     = 2'b01,
    TAIL     = 2'b10,
    HEADTAIL = 2'b11
  } flit_type_e;

  typedef enum logic [2:0] {
    IPC_IDLE    = 3'd0,
    IPC_DECODE  = 3'd1,
    IPC_ALLOC   = 3'd2,
    IPC_FORWARD = 3'd3,
    IPC_DROP    = 3'd4
  } ipc_state_e;

  // Flit opens a packet
  function automatic logic is_head_type(input logic [FLIT_TYPE_W-1:0] t);
    return (t == HEAD) || (t == HEADTAIL);
  endfunction

  // Flit closes a packet
  function automatic logic is_tail_type(input logic [FLIT_TYPE_W-1:0] t);
    return (t == TAIL) || (t == HEADTAIL);
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// Circular flit buffer with registered full/empty; read data is the head entry.
module flit_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_c,
  output logic             empty_o,
  output logic             full_next_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push_ok, pop_ok;

  // Pointer and occupancy update; push ignored when full, pop ignored when empty
  always_comb begin
    push_ok  = push_i & ~full_q;
    pop_ok   = pop_i & ~empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  // Control state
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage; contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_c     = mem_q[rd_ptr_q];
  assign empty_o     = empty_q;
  assign full_next_c = full_d;

endmodule

// File: rtl/input_port_controller.sv
// Router input port: buffers flits, drives head decode, requests the output
// port and streams the packet to the crossbar, or discards dropped packets.
// Optional INPUT_PORT_STATS_EN adds drop_count/stray_count saturating counters.
module input_port_controller
  import noc_router_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned REQUEST_WIDTH = 3,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic [1:0]               in_type,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     decodeHeadFlit,
  output logic [DATA_WIDTH-1:0]    HeadFlit,
  input  logic                     headFlitDecoded,
  input  logic [REQUEST_WIDTH-1:0] RequestMessage,
  input  logic                     dropPacket,
  input  logic                     updateHeadFlit,
  input  logic [DATA_WIDTH-1:0]    newHeadFlit,
  output logic [REQUEST_WIDTH-1:0] out_request,
  output logic                     out_request_valid,
  input  logic                     out_grant,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic [1:0]               out_type,
  output logic                     out_valid,
  input  logic                     out_ready
`ifdef INPUT_PORT_STATS_EN
  ,
  output logic [15:0]              drop_count,
  output logic [15:0]              stray_count
`endif
);

  localparam int unsigned ENTRY_W = DATA_WIDTH + FLIT_TYPE_W;

  localparam logic [2:0] ST_IDLE    = IPC_IDLE;
  localparam logic [2:0] ST_DECODE  = IPC_DECODE;
  localparam logic [2:0] ST_ALLOC   = IPC_ALLOC;
  localparam logic [2:0] ST_FORWARD = IPC_FORWARD;
  localparam logic [2:0] ST_DROP    = IPC_DROP;

  // Reject configurations that cannot hold the TTL field or wrap the pointers
  if (DATA_WIDTH < TTL_MSB + 1 || TTL_MSB < TTL_LSB) begin : g_bad_width
    $error("input_port_controller: DATA_WIDTH too narrow for TTL field");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("input_port_controller: FIFO_DEPTH must be a power of 2 and >= 2");
  end

  logic [2:0]               state_q, state_d;
  logic [REQUEST_WIDTH-1:0] req_q, req_d;
  logic [DATA_WIDTH-1:0]    head_q, head_d;
  logic                     first_q, first_d;
  logic                     in_ready_q;

  logic                     fifo_push;
  logic                     fifo_pop;
  logic [ENTRY_W-1:0]       fifo_rdata;
  logic                     fifo_empty;
  logic                     fifo_full_next;
  logic [1:0]               head_type;
  logic [DATA_WIDTH-1:0]    head_data;

  assign fifo_push = in_valid & in_ready_q;
  assign head_type = fifo_rdata[ENTRY_W-1 -: FLIT_TYPE_W];
  assign head_data = fifo_rdata[DATA_WIDTH-1:0];

  flit_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_ni      (rst),
    .push_i      (fifo_push),
    .wdata_i     ({in_type, in_data}),
    .pop_i       (fifo_pop),
    .rdata_c     (fifo_rdata),
    .empty_o     (fifo_empty),
    .full_next_c (fifo_full_next)
  );

  // Packet FSM: next state, route/head latching, FIFO pop and port outputs
  always_comb begin
    state_d           = state_q;
    req_d             = req_q;
    head_d            = head_q;
    first_d           = first_q;
    fifo_pop          = 1'b0;
    decodeHeadFlit    = 1'b0;
    HeadFlit          = '0;
    out_request_valid = 1'b0;
    out_valid         = 1'b0;
    out_data          = '0;
    out_type          = '0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (is_head_type(head_type)) state_d  = ST_DECODE;
          else                         fifo_pop = 1'b1;
        end
      end

      ST_DECODE: begin
        decodeHeadFlit = 1'b1;
        HeadFlit       = head_data;
        if (headFlitDecoded) begin
          if (dropPacket) begin
            state_d = ST_DROP;
          end else begin
            req_d   = RequestMessage;
            head_d  = updateHeadFlit ? newHeadFlit : head_data;
            state_d = ST_ALLOC;
          end
        end
      end

      ST_ALLOC: begin
        out_request_valid = 1'b1;
        if (out_grant) begin
          state_d = ST_FORWARD;
          first_d = 1'b1;
        end
      end

      ST_FORWARD: begin
        if (!fifo_empty) begin
          out_valid = 1'b1;
          out_data  = first_q ? head_q : head_data;
          out_type  = head_type;
          if (out_ready) begin
            fifo_pop = 1'b1;
            first_d  = 1'b0;
            if (is_tail_type(head_type)) state_d = ST_IDLE;
          end
        end
      end

      ST_DROP: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (is_tail_type(head_type)) state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and packet context registers; in_ready tracks the FIFO's next full flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      head_q     <= '0;
      first_q    <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      head_q     <= head_d;
      first_q    <= first_d;
      in_ready_q <= ~fifo_full_next;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_request = req_q;

`ifdef INPUT_PORT_STATS_EN
  logic [15:0] drop_cnt_q;
  logic [15:0] stray_cnt_q;
  logic        drop_evt;
  logic        stray_evt;

  assign drop_evt  = (state_q == ST_DROP) && (state_d == ST_IDLE);
  assign stray_evt = (state_q == ST_IDLE) && fifo_pop;

  // Saturating event counters for discarded packets and stray flits
  always_ff @(posedge clk) begin
    if (!rst) begin
      drop_cnt_q  <= '0;
      stray_cnt_q <= '0;
    end else begin
      if (drop_evt && (drop_cnt_q != 16'hFFFF))   drop_cnt_q  <= drop_cnt_q + 16'd1;
      if (stray_evt && (stray_cnt_q != 16'hFFFF)) stray_cnt_q <= stray_cnt_q + 16'd1;
    end
  end

  assign drop_count  = drop_cnt_q;
  assign stray_count = stray_cnt_q;
`endif

endmodule

// File: tb/tb_input_port_controller.sv
// Directed bench for input_port_controller with an output-flit scoreboard.
module tb_input_port_controller;
  import noc_router_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] in_data = '0;
  logic [1:0]  in_type = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        decodeHeadFlit;
  logic [31:0] HeadFlit;
  logic        headFlitDecoded = 1'b0;
  logic [2:0]  RequestMessage = '0;
  logic        dropPacket = 1'b0;
  logic        updateHeadFlit = 1'b0;
  logic [31:0] newHeadFlit = '0;
  logic [2:0]  out_request;
  logic        out_request_valid;
  logic        out_grant = 1'b0;
  logic [31:0] out_data;
  logic [1:0]  out_type;
  logic        out_valid;
  logic        out_ready = 1'b0;
`ifdef INPUT_PORT_STATS_EN
  logic [15:0] drop_count;
  logic [15:0] stray_count;
`endif

  int errors = 0;
  int checks = 0;
  int req_cycles = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  ftype;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  input_port_controller dut (
    .clk               (clk),
    .rst               (rst),
    .in_data           (in_data),
    .in_type           (in_type),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .decodeHeadFlit    (decodeHeadFlit),
    .HeadFlit          (HeadFlit),
    .headFlitDecoded   (headFlitDecoded),
    .RequestMessage    (RequestMessage),
    .dropPacket        (dropPacket),
    .updateHeadFlit    (updateHeadFlit),
    .newHeadFlit       (newHeadFlit),
    .out_request       (out_request),
    .out_request_valid (out_request_valid),
    .out_grant         (out_grant),
    .out_data          (out_data),
    .out_type          (out_type),
    .out_valid         (out_valid),
    .out_ready         (out_ready)
`ifdef INPUT_PORT_STATS_EN
    ,
    .drop_count        (drop_count),
    .stray_count       (stray_count)
`endif
  );

  always #5 clk = ~clk;

  // Output monitor: every accepted flit must match the scoreboard head
  always @(negedge clk) begin
    if (out_request_valid) req_cycles++;
    if (rst && out_valid && out_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_flit: observed data=0x%0h type=%0d expected none", out_data, out_type);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        checks++;
        assert (out_data === mon_e.data && out_type === mon_e.ftype) else begin
          errors++;
          $error("FAIL flit_order: observed data=0x%0h type=%0d expected data=0x%0h type=%0d",
                 out_data, out_type, mon_e.data, mon_e.ftype);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_flit(input logic [31:0] d, input logic [1:0] t);
    exp_q.push_back({d, t});
  endtask

  // Present one flit and hold it until accepted
  task automatic send_flit(input logic [31:0] d, input logic [1:0] t);
    int n = 0;
    in_data  = d;
    in_type  = t;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("send_accept", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Act as the head decoder for one decode request
  task automatic do_decode(input logic [31:0] exp_head, input logic [2:0] rm,
                           input logic drop, input logic upd, input logic [31:0] newh);
    int n = 0;
    while (!decodeHeadFlit && n < 50) begin
      tick();
      n++;
    end
    check("decode_strobe", 64'(decodeHeadFlit), 64'd1);
    check("head_flit", 64'(HeadFlit), 64'(exp_head));
    headFlitDecoded = 1'b1;
    RequestMessage  = rm;
    dropPacket      = drop;
    updateHeadFlit  = upd;
    newHeadFlit     = newh;
    tick();
    headFlitDecoded = 1'b0;
    dropPacket      = 1'b0;
    updateHeadFlit  = 1'b0;
  endtask

  // Act as the allocator: hold off for 'delay' cycles, then pulse grant
  task automatic do_grant(input logic [2:0] exp_req, input int delay);
    int n = 0;
    while (!out_request_valid && n < 50) begin
      tick();
      n++;
    end
    for (int i = 0; i < delay; i++) begin
      check("req_held_valid", 64'(out_request_valid), 64'd1);
      check("req_held_value", 64'(out_request), 64'(exp_req));
      check("no_valid_before_grant", 64'(out_valid), 64'd0);
      tick();
    end
    check("req_valid", 64'(out_request_valid), 64'd1);
    check("req_value", 64'(out_request), 64'(exp_req));
    out_grant = 1'b1;
    tick();
    out_grant = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int req_before;

    // Reset
    rst = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_decode", 64'(decodeHeadFlit), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_req_valid", 64'(out_request_valid), 64'd0);
    check("rst_out_request", 64'(out_request), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    rst = 1'b1;
    tick();
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // 3-flit packet with TTL-updated head
    out_ready = 1'b1;
    expect_flit(32'h0000_0305, HEAD);
    expect_flit(32'h0000_00B1, BODY);
    expect_flit(32'h0000_00B2, TAIL);
    send_flit(32'h0000_0005, HEAD);
    send_flit(32'h0000_00B1, BODY);
    send_flit(32'h0000_00B2, TAIL);
    do_decode(32'h0000_0005, 3'd2, 1'b0, 1'b1, 32'h0000_0305);
    do_grant(3'd2, 0);
    wait_drain();
    tick();
    check("t1_idle_req", 64'(out_request_valid), 64'd0);
    check("t1_idle_decode", 64'(decodeHeadFlit), 64'd0);
    check("t1_idle_valid", 64'(out_valid), 64'd0);

    // Dropped HEADTAIL, with decode latency
    req_before = req_cycles;
    send_flit(32'h0000_00AA, HEADTAIL);
    check("lat_decode_early", 64'(decodeHeadFlit), 64'd0);
    tick();
    check("lat_decode_on", 64'(decodeHeadFlit), 64'd1);
    do_decode(32'h0000_00AA, 3'd1, 1'b1, 1'b0, 32'h0);
    repeat (5) tick();
    check("drop_no_request", 64'(req_cycles), 64'(req_before));
    check("drop_no_valid", 64'(out_valid), 64'd0);
    check("drop_in_ready", 64'(in_ready), 64'd1);
`ifdef INPUT_PORT_STATS_EN
    check("drop_count", 64'(drop_count), 64'd1);
`endif

    // Stray BODY in IDLE, then a valid single-flit packet
    expect_flit(32'h0000_1234, HEADTAIL);
    send_flit(32'h0000_0077, BODY);
    send_flit(32'h0000_1234, HEADTAIL);
    do_decode(32'h0000_1234, 3'd5, 1'b0, 1'b0, 32'h0);
    do_grant(3'd5, 0);
    wait_drain();
`ifdef INPUT_PORT_STATS_EN
    check("stray_count", 64'(stray_count), 64'd1);
`endif

    // 5-flit packet with back-pressure: FIFO fills after 4 flits
    out_ready = 1'b0;
    expect_flit(32'h0000_0300, HEAD);
    expect_flit(32'h0000_0301, BODY);
    expect_flit(32'h0000_0302, BODY);
    expect_flit(32'h0000_0303, BODY);
    expect_flit(32'h0000_0304, TAIL);
    send_flit(32'h0000_0300, HEAD);
    send_flit(32'h0000_0301, BODY);
    send_flit(32'h0000_0302, BODY);
    send_flit(32'h0000_0303, BODY);
    check("full_in_ready", 64'(in_ready), 64'd0);
    do_decode(32'h0000_0300, 3'd3, 1'b0, 1'b0, 32'h0);
    do_grant(3'd3, 0);
    repeat (3) tick();
    check("bp_out_valid", 64'(out_valid), 64'd1);
    check("bp_out_data", 64'(out_data), 64'h0000_0300);
    check("bp_out_type", 64'(out_type), 64'(HEAD));
    check("bp_still_full", 64'(in_ready), 64'd0);
    check("bp_none_sent", 64'(exp_q.size()), 64'd5);
    out_ready = 1'b1;
    send_flit(32'h0000_0304, TAIL);
    wait_drain();
    tick();
    check("bp_in_ready_after", 64'(in_ready), 64'd1);

    // Grant held off for 10 cycles
    expect_flit(32'h0000_4343, HEADTAIL);
    send_flit(32'h0000_4242, HEADTAIL);
    do_decode(32'h0000_4242, 3'd6, 1'b0, 1'b1, 32'h0000_4343);
    do_grant(3'd6, 10);
    wait_drain();

    // Reset in the middle of a packet, after the first flit has left
    out_ready = 1'b0;
    expect_flit(32'h0000_0010, HEAD);
    send_flit(32'h0000_0010, HEAD);
    send_flit(32'h0000_0011, BODY);
    send_flit(32'h0000_0012, TAIL);
    do_decode(32'h0000_0010, 3'd4, 1'b0, 1'b0, 32'h0);
    do_grant(3'd4, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("mid_first_sent", 64'(exp_q.size()), 64'd0);
    rst = 1'b0;
    tick();
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_data", 64'(out_data), 64'd0);
    check("mid_rst_out_type", 64'(out_type), 64'd0);
    check("mid_rst_req_valid", 64'(out_request_valid), 64'd0);
    check("mid_rst_request", 64'(out_request), 64'd0);
    check("mid_rst_decode", 64'(decodeHeadFlit), 64'd0);
    check("mid_rst_headflit", 64'(HeadFlit), 64'd0);
`ifdef INPUT_PORT_STATS_EN
    check("mid_rst_drop_count", 64'(drop_count), 64'd0);
    check("mid_rst_stray_count", 64'(stray_count), 64'd0);
`endif
    rst = 1'b1;
    tick();
    check("mid_post_in_ready", 64'(in_ready), 64'd1);
    check("mid_post_out_valid", 64'(out_valid), 64'd0);

    // Fresh packet after reset, with the minimum-latency path to out_valid
    out_ready = 1'b1;
    expect_flit(32'h0000_0099, HEADTAIL);
    send_flit(32'h0000_0099, HEADTAIL);
    check("post_decode_early", 64'(decodeHeadFlit), 64'd0);
    tick();
    do_decode(32'h0000_0099, 3'd1, 1'b0, 1'b0, 32'h0);
    do_grant(3'd1, 0);
    check("lat_out_valid", 64'(out_valid), 64'd1);
    wait_drain();
`ifdef INPUT_PORT_STATS_EN
    check("post_stray_count", 64'(stray_count), 64'd0);
`endif
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/input_port_controller.md
Name: input_port_controller

Overview:
- Per-input-port front end of the mesh router: buffers incoming flits, hands each head flit to HeadFlitDecoder, and latches the returned route.
- Requests the output port from the switch allocator and streams the packet through once granted.
- Silently discards packets the decoder flags as expired (dropPacket).
- Sits between the link receiver and the crossbar input, and is the sole driver of the decoder's decodeHeadFlit/HeadFlit.

Parameters:
- DATA_WIDTH, 32, flit payload width; must be >= 20 because the TTL field is bits 19:8.
- REQUEST_WIDTH, 3, width of the route/output-port request; matches HeadFlitDecoder.
- FIFO_DEPTH, 4, input buffer depth in flits; power of 2, >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- in_data  in  DATA_WIDTH  incoming flit payload
- in_type  in  2  flit type: 00 BODY, 01 HEAD, 10 TAIL, 11 HEADTAIL
- in_valid  in  1  upstream flit valid
- in_ready  out  1  buffer can accept; registered, equals !full
- decodeHeadFlit  out  1  decode strobe to HeadFlitDecoder
- HeadFlit  out  DATA_WIDTH  head flit presented to the decoder (FIFO head data)
- headFlitDecoded  in  1  decoder done
- RequestMessage  in  REQUEST_WIDTH  decoded output port
- dropPacket  in  1  decoder says discard this packet
- updateHeadFlit  in  1  use newHeadFlit in place of the original head
- newHeadFlit  in  DATA_WIDTH  TTL-updated head flit
- out_request  out  REQUEST_WIDTH  latched route to the switch allocator
- out_request_valid  out  1  allocation request
- out_grant  in  1  allocator grant, 1-cycle pulse
- out_data  out  DATA_WIDTH  flit to the crossbar
- out_type  out  2  flit type to the crossbar
- out_valid  out  1  out_data valid
- out_ready  in  1  crossbar/downstream accepts

Behaviour:
- Reset: rst low at a clk edge empties the FIFO, puts the FSM in IDLE and clears req_reg, head_reg and first_flag. This applies mid-packet too: the partial packet is lost.
- Values while/after reset: in_ready=0 while rst is low and 1 in the first cycle after. All other outputs are 0.
- FIFO push: push on in_valid & in_ready. A flit written at edge t is visible at the head at t+1; there is no bypass. Pointers wrap modulo FIFO_DEPTH.
- Full/simultaneous: when full, in_ready=0 even if a pop happens in the same cycle. Push and pop in the same cycle are legal when neither full nor empty.
- FSM states: IDLE, DECODE, ALLOC, FORWARD, DROP.
- IDLE, head-type flit at FIFO head: HEAD or HEADTAIL -> DECODE.
- IDLE, stray flit at FIFO head: BODY or TAIL -> pop it and stay in IDLE.
- IDLE, empty FIFO: stay.
- DECODE: decodeHeadFlit=1 combinationally from state; HeadFlit = FIFO head data. On headFlitDecoded:
  - dropPacket=1 -> DROP.
  - otherwise: req_reg <= RequestMessage; head_reg <= updateHeadFlit ? newHeadFlit : FIFO head data; -> ALLOC.
- ALLOC: out_request_valid=1, out_request=req_reg. On out_grant -> FORWARD with first_flag=1.
- FORWARD: out_valid = !empty. out_data = first_flag ? head_reg : FIFO head data; out_type = FIFO head type.
  - Pop on out_valid & out_ready, which clears first_flag.
  - Popped type TAIL or HEADTAIL -> IDLE.
  - Popped type HEAD mid-packet (protocol error) is forwarded as-is.
- DROP: pop every cycle the FIFO is non-empty; out_valid=0. Popped type TAIL or HEADTAIL -> IDLE.
- Latency: head written at edge t gives decodeHeadFlit high in cycle t+2. With an immediate decode and same-cycle grant, out_valid is high in cycle t+4.
- Ordering: at most one packet in flight per port; the next head waits in the FIFO until the FSM returns to IDLE.

Optional Feature:
- Macro: INPUT_PORT_STATS_EN.
- When defined, adds two output ports, both 16-bit saturating counters cleared by reset:
  - drop_count: increments on each DROP -> IDLE transition.
  - stray_count: increments on each stray pop in IDLE.
- When undefined, both ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package noc_router_pkg:
  - flit_type_e enum (BODY, HEAD, TAIL, HEADTAIL), 2-bit.
  - ipc_state_e enum.
  - TTL_LSB=8 and TTL_MSB=19 constants.
- Sub-module flit_fifo(DATA_WIDTH+2, FIFO_DEPTH): circular buffer with registered full/empty, instantiated once.

Test Plan:
- 3-flit packet HEAD 0x00000005, BODY, TAIL; decoder returns RequestMessage=2 and updateHeadFlit=1 with newHeadFlit=0x00000305; grant in the first ALLOC cycle -> out_request=2; first out_data=0x00000305, then body and tail unchanged; FSM back in IDLE.
- HEADTAIL flit with dropPacket=1 -> out_request_valid never asserted, out_valid stays 0, FIFO empty afterwards; drop_count=1 with INPUT_PORT_STATS_EN.
- 5-flit packet with out_ready=0 throughout FORWARD -> in_ready low after 4 flits buffered; release out_ready -> all 5 flits delivered in order with no loss or duplication.
- BODY flit arriving in IDLE, followed by a valid HEAD/TAIL packet -> stray flit discarded, stray_count=1, the following packet routed normally.
- rst driven low while in FORWARD after 1 of 3 flits sent -> next cycle state IDLE, FIFO empty, every output 0; first cycle after reset in_ready=1; a new packet afterwards routes correctly.
- Grant delayed 10 cycles -> out_request_valid held 10 cycles with constant out_request; no out_valid before the grant.
